irq_ctrl: RTL and testbench

Memory-mapped interrupt controller for the cpu6502 system bus. Collects up to eight external interrupt requests and synchronises them. It latches edge-type requests, applies a software mask, and drives the CPU `irq` input. It also stretches an external NMI request into a fixed-width `nmi` pulse. Firmware reaches it through a 4-byte register window decoded on the same `addr`/`odata`/`rw` bus the ROM and RAM sit on.

---
 rtl/irq_ctrl_pkg.sv | 23 ++
 rtl/irq_ctrl_if.sv | 12 +
 rtl/irq_ctrl_sync_edge.sv | 25 ++
 rtl/irq_ctrl.sv | 105 ++++++++++
 tb/tb_irq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared register map and helpers for the irq_ctrl interrupt controller.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_MASK   = 2'd1,
    REG_MODE   = 2'd2,
    REG_VECTOR = 2'd3
  } reg_off_e;

  localparam logic [7:0] VECTOR_NONE = 8'h80;

  // Lowest-numbered active bit wins; 8'h80 when nothing is active.
  function automatic logic [7:0] vector_of(input logic [7:0] act);
    logic [7:0] v;
    v = VECTOR_NONE;
    for (int unsigned i = 8; i > 0; i--) begin
      if (act[i-1]) v = 8'(i - 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// cpu6502 system-bus slice seen by the interrupt controller's register window.
interface irq_ctrl_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        rw;
  logic        phi2;
  logic [7:0]  rdata;
  logic        rsel;

  modport master (output addr, wdata, rw, phi2, input rdata, rsel);
  modport slave  (input addr, wdata, rw, phi2, output rdata, rsel);
endinterface

// File: rtl/irq_ctrl_sync_edge.sv
// One-bit two-flop synchroniser with a previous-value flop for rise detection.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronised IRQ sources with mask/mode
// registers, priority vector, and a stretched NMI pulse.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [15:0] BASE       = 16'hD000,
  parameter int unsigned NSRC       = 8,
  parameter int unsigned NMI_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  irq_ctrl_if.slave       bus,
  input  logic [NSRC-1:0] src,
  input  logic            nmi_src,
  output logic            irq,
  output logic            nmi
);
  localparam logic [3:0] NMI_LOAD = 4'(NMI_CYCLES);

  logic [NSRC-1:0] lvl, rise, pending, mask, mode, clr, wbits;
  logic            nmi_rise, nmi_level_unused;
  logic [3:0]      nmi_cnt;
  logic [15:0]     offset;
  logic            hit, commit, wr_done;
  reg_off_e        reg_sel;
  logic [7:0]      rd;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    irq_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (src[i]),
      .level (lvl[i]),
      .rise  (rise[i])
    );
  end

  irq_sync_edge u_nmi_sync (
    .clk   (clk),
    .reset (reset),
    .d     (nmi_src),
    .level (nmi_level_unused),
    .rise  (nmi_rise)
  );

  // Subtracting BASE keeps the window decode correct for any BASE alignment.
  assign offset  = bus.addr - BASE;
  assign hit     = (offset[15:2] == '0);
  assign reg_sel = reg_off_e'(offset[1:0]);
  assign commit  = hit & ~bus.rw & bus.phi2 & ~wr_done;
  assign wbits   = bus.wdata[NSRC-1:0];

  always_comb begin
    clr = '0;
    if (commit && reg_sel == REG_STATUS) clr = wbits & mode;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_done <= 1'b0;
      mask    <= '0;
      mode    <= '0;
    end else begin
      if (!bus.phi2)   wr_done <= 1'b0;
      else if (commit) wr_done <= 1'b1;
      if (commit && reg_sel == REG_MASK) mask <= wbits;
      if (commit && reg_sel == REG_MODE) mode <= wbits;
    end
  end

  // Edge bits: a new rise beats a same-cycle clear. Level bits track s2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      pending <= (mode & (rise | (pending & ~clr))) | (~mode & lvl);
      irq     <= |(pending & mask);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_cnt <= '0;
      nmi     <= 1'b0;
    end else begin
      if (nmi_rise)            nmi_cnt <= NMI_LOAD;
      else if (nmi_cnt != '0)  nmi_cnt <= nmi_cnt - 4'd1;
      nmi <= (nmi_cnt != '0);
    end
  end

  always_comb begin
    rd = '0;
    case (reg_sel)
      REG_STATUS: rd = 8'(pending);
      REG_MASK:   rd = 8'(mask);
      REG_MODE:   rd = 8'(mode);
      REG_VECTOR: rd = vector_of(8'(pending & mask));
    endcase
  end

  assign bus.rsel  = hit & bus.rw;
  assign bus.rdata = bus.rsel ? rd : '0;
endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: register-map vector table, timing sequences, and a
// randomized run compared against a time-stamp based reference model.
module tb_irq_ctrl;
  localparam logic [15:0] BASE       = 16'hD000;
  localparam int          NSRC       = 8;
  localparam int          NMI_CYCLES = 4;
  localparam logic [15:0] A_STATUS   = BASE;
  localparam logic [15:0] A_MASK     = BASE + 16'd1;
  localparam logic [15:0] A_MODE     = BASE + 16'd2;
  localparam logic [15:0] A_VECTOR   = BASE + 16'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src;
  logic       nmi_src;
  logic       irq, nmi;

  irq_ctrl_if bus ();

  irq_ctrl #(.BASE(BASE), .NSRC(NSRC), .NMI_CYCLES(NMI_CYCLES)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .src     (src),
    .nmi_src (nmi_src),
    .irq     (irq),
    .nmi     (nmi)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, want %02h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_pend, m_mask, m_mode, m_h0, m_h1, m_h2;
  logic       m_irq, m_nmi, m_wdone, m_n0, m_n1, m_n2;
  int         m_cyc, m_last;

  task automatic model_edge();
    logic [15:0] off;
    logic        commit;
    logic [7:0]  lvl, rse, clr;
    off    = bus.addr - BASE;
    commit = bus.phi2 && !bus.rw && (off < 16'd4) && !m_wdone;
    lvl    = m_h1;
    rse    = m_h1 & ~m_h2;
    clr    = (commit && off == 16'd0) ? bus.wdata : 8'h00;
    m_irq  = |(m_pend & m_mask);
    for (int i = 0; i < 8; i++)
      m_pend[i] = m_mode[i] ? (rse[i] | (m_pend[i] & ~clr[i])) : lvl[i];
    if (commit && off == 16'd1) m_mask = bus.wdata;
    if (commit && off == 16'd2) m_mode = bus.wdata;
    m_wdone = bus.phi2 ? (m_wdone | commit) : 1'b0;
    m_cyc++;
    m_nmi = (m_cyc - m_last >= 1) && (m_cyc - m_last <= NMI_CYCLES);
    if (m_n1 && !m_n2) m_last = m_cyc;
    m_h2 = m_h1; m_h1 = m_h0; m_h0 = src;
    m_n2 = m_n1; m_n1 = m_n0; m_n0 = nmi_src;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = 8'h00; m_mask = 8'h00; m_mode = 8'h00;
      m_h0 = 8'h00; m_h1 = 8'h00; m_h2 = 8'h00;
      m_irq = 1'b0; m_nmi = 1'b0; m_wdone = 1'b0;
      m_n0 = 1'b0; m_n1 = 1'b0; m_n2 = 1'b0;
      m_cyc = 0; m_last = -1000;
    end else begin
      model_edge();
    end
  end

  function automatic logic [8:0] m_read(input logic [15:0] a, input logic rw);
    logic [15:0] off;
    logic [7:0]  act, v;
    off = a - BASE;
    if (!rw || off >= 16'd4) return 9'h000;
    case (off)
      16'd0:   v = m_pend;
      16'd1:   v = m_mask;
      16'd2:   v = m_mode;
      default: begin
        act = m_pend & m_mask;
        v   = 8'h80;
        for (int i = 7; i >= 0; i--) if (act[i]) v = 8'(i);
      end
    endcase
    return {1'b1, v};
  endfunction

  // ---------------- bus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    bus.addr = a;
    bus.rw   = 1'b1;
    #1;
    check(name, bus.rdata, exp);
  endtask

  task automatic wr_commit(input logic [15:0] a, input logic [7:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.rw    = 1'b0;
    bus.phi2  = 1'b1;
    tick();
  endtask

  task automatic wr_end();
    bus.phi2 = 1'b0;
    bus.rw   = 1'b1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    wr_commit(a, d);
    wr_end();
    tick();
  endtask

  // drv bit i is nmi_src before edge i+1; exp bit i is nmi after that edge.
  task automatic nmi_run(input string tag, input logic [11:0] drv, input logic [11:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      nmi_src = drv[i];
      tick();
      check($sformatf("%s_e%0d", tag, i + 1), 8'(nmi), 8'(exp[i]));
    end
    nmi_src = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdat;
    logic        rw;
    logic [7:0]  exp_rd;
    logic        exp_sel;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    logic [4:0] hold_exp;
    logic [8:0] mr;

    tbl[0]  = '{1'b0, A_STATUS,      8'h00, 1'b1, 8'h00, 1'b1};
    tbl[1]  = '{1'b0, A_MASK,        8'h00, 1'b1, 8'h00, 1'b1};
    tbl[2]  = '{1'b0, A_MODE,        8'h00, 1'b1, 8'h00, 1'b1};
    tbl[3]  = '{1'b0, A_VECTOR,      8'h00, 1'b1, 8'h80, 1'b1};
    tbl[4]  = '{1'b0, 16'hCFFF,      8'h00, 1'b1, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 16'hD004,      8'h00, 1'b1, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, A_MASK,        8'h00, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, A_MASK,        8'hA5, 1'b1, 8'hA5, 1'b1};
    tbl[8]  = '{1'b1, A_MODE,        8'h3C, 1'b1, 8'h3C, 1'b1};
    tbl[9]  = '{1'b1, A_VECTOR,      8'hFF, 1'b1, 8'h80, 1'b1};
    tbl[10] = '{1'b1, A_STATUS,      8'hFF, 1'b1, 8'h00, 1'b1};
    tbl[11] = '{1'b1, A_MASK,        8'h00, 1'b1, 8'h00, 1'b1};
    tbl[12] = '{1'b1, A_MODE,        8'h00, 1'b1, 8'h00, 1'b1};

    reset = 1'b1; src = 8'h00; nmi_src = 1'b0;
    bus.addr = 16'h0000; bus.wdata = 8'h00; bus.rw = 1'b1; bus.phi2 = 1'b0;
    #1;
    check("rst_irq", 8'(irq), 8'h00);
    check("rst_nmi", 8'(nmi), 8'h00);
    check("rst_rsel", 8'(bus.rsel), 8'h00);
    check("rst_rdata", bus.rdata, 8'h00);
    tick(); tick();
    reset = 1'b0;
    tick();

    // register map vectors
    foreach (tbl[k]) begin
      if (tbl[k].wr) bus_write(tbl[k].addr, tbl[k].wdat);
      bus.addr = tbl[k].addr;
      bus.rw   = tbl[k].rw;
      #1;
      check($sformatf("tbl%0d_rdata", k), bus.rdata, tbl[k].exp_rd);
      check($sformatf("tbl%0d_rsel", k), 8'(bus.rsel), 8'(tbl[k].exp_sel));
      bus.rw = 1'b1;
    end

    // level mode latency
    bus_write(A_MASK, 8'h05);
    bus_write(A_MODE, 8'h00);
    src = 8'h04;
    tick(); tick();
    check("lvl_irq_e2", 8'(irq), 8'h00);
    tick();
    check("lvl_irq_e3", 8'(irq), 8'h00);
    rd_check("lvl_status_e3", A_STATUS, 8'h04);
    tick();
    check("lvl_irq_e4", 8'(irq), 8'h01);
    rd_check("lvl_vector", A_VECTOR, 8'h02);
    src = 8'h00;
    tick(); tick(); tick();
    check("lvl_drop_e3", 8'(irq), 8'h01);
    tick();
    check("lvl_drop_e4", 8'(irq), 8'h00);

    // edge mode latch and W1C
    bus_write(A_MODE, 8'h01);
    bus_write(A_MASK, 8'h01);
    src = 8'h01;
    tick(); tick(); tick();
    src = 8'h00;
    tick(); tick(); tick(); tick();
    rd_check("edge_status_held", A_STATUS, 8'h01);
    check("edge_irq_held", 8'(irq), 8'h01);
    wr_commit(A_STATUS, 8'h01);
    rd_check("w1c_status", A_STATUS, 8'h00);
    check("w1c_irq_k", 8'(irq), 8'h01);
    wr_end();
    tick();
    check("w1c_irq_k1", 8'(irq), 8'h00);

    // rise landing on the W1C commit edge
    src = 8'h01;
    tick(); tick();
    wr_commit(A_STATUS, 8'h01);
    rd_check("coincide_status", A_STATUS, 8'h01);
    wr_end();
    tick();
    check("coincide_irq", 8'(irq), 8'h01);
    src = 8'h00;
    tick(); tick(); tick();
    rd_check("pre_hold_status", A_STATUS, 8'h01);

    // write held for a whole phi2 phase: one commit only
    bus.addr = A_STATUS; bus.wdata = 8'h01; bus.rw = 1'b0; bus.phi2 = 1'b1;
    src = 8'h01;
    hold_exp = 5'b11001;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_irq_e%0d", i + 1), 8'(irq), 8'(hold_exp[i]));
    end
    rd_check("hold_status", A_STATUS, 8'h01);
    wr_end();
    tick();
    src = 8'h00;

    // NMI stretching
    nmi_run("nmi_single", 12'b000000000001, 12'b000001111000, 10);
    nmi_run("nmi_extend", 12'b000000000101, 12'b000111111000, 11);
    nmi_run("nmi_prerst", 12'b000000000001, 12'b000000011000, 5);
    reset = 1'b1;
    #1;
    check("rst_mid_nmi", 8'(nmi), 8'h00);
    check("rst_mid_irq", 8'(irq), 8'h00);
    rd_check("rst_mid_status", A_STATUS, 8'h00);

    // write during reset is discarded; held level source returns after 3 edges
    src = 8'h01;
    wr_commit(A_MASK, 8'hFF);
    wr_end();
    tick();
    reset = 1'b0;
    tick(); tick();
    rd_check("rst_src_e2", A_STATUS, 8'h00);
    tick();
    rd_check("rst_src_e3", A_STATUS, 8'h01);
    rd_check("rst_mask", A_MASK, 8'h00);
    tick();
    check("rst_src_irq", 8'(irq), 8'h00);

    // randomized run against the reference model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(3) == 0) src = 8'($urandom);
      if ($urandom_range(5) == 0) nmi_src = ~nmi_src;
      if ($urandom_range(2) == 0) bus.phi2 = ~bus.phi2;
      bus.rw    = ($urandom_range(3) == 0) ? 1'b0 : 1'b1;
      bus.addr  = A_STATUS + 16'($urandom_range(5)) - 16'd1;
      bus.wdata = 8'($urandom);
      tick();
      check("rand_irq", 8'(irq), 8'(m_irq));
      check("rand_nmi", 8'(nmi), 8'(m_nmi));
      mr = m_read(bus.addr, bus.rw);
      check("rand_rsel", 8'(bus.rsel), 8'(mr[8]));
      check("rand_rdata", bus.rdata, mr[7:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
